// File: rtl/imm_extend_buf.sv
// Two-entry in-order FIFO of extended immediates. The extension is computed
// combinationally from data_i/mode_i and stored on the accept edge.
module imm_extend_buf #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [1:0]       count_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1 on the same side; ready_o and valid_o depend only on occupancy.

    generate
        if (IN_W < 1 || OUT_W < IN_W + 2) begin : g_bad_params
            $error("imm_extend_buf: OUT_W must be >= IN_W+2 and IN_W >= 1");
        end
    endgenerate

    logic [OUT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;

    always_comb begin
        sext = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};
        ext  = '0;
        case (mode_i)
            2'b00:   ext = {{(OUT_W-IN_W){1'b0}}, data_i};
            2'b01:   ext = sext;
            2'b10:   ext = {data_i, {(OUT_W-IN_W){1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign ready_o = (count != 2'd2);
    assign valid_o = (count != 2'd0);
    assign count_o = count;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // A push into the free slot never touches the head, so data_o stays stable
    // under backpressure.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ext;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
